// File: rtl/lcd_send_char.sv
// lcd_send_char: drives HD44780-style character LCD pins for one byte per request.
// Sequence per byte: SETUP (E low, bus stable) -> PULSE (E high) -> HOLD (E low,
// bus held) -> EXEC (fixed execution wait) -> DONE (one-cycle sendCharDone).
// The LCD busy flag is never polled; execution time is covered by fixed waits.
module lcd_send_char #(
  parameter int SETUP_CYC     = 1,
  parameter int E_HIGH_CYC    = 1,
  parameter int HOLD_CYC      = 1,
  parameter int EXEC_CYC      = 80,
  parameter int LONG_EXEC_CYC = 3200,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dataReady,
  input  logic [7:0] charIn,
  input  logic       RSin,
  input  logic       RWin,
  output logic       sendCharDone,
  output logic       busy,
  output logic       lcdE,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic [7:0] lcdData,
  output logic       lcdDataOe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Phase counters load (length - 1) and count down to zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_HI_LD  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       char_r, char_s;
  logic             rs_r, rs_s;
  logic             rw_r, rw_s;
  logic             cnt_zero_s;
  logic             long_cmd_s;

  assign cnt_zero_s = (cnt_r == CNT_ZERO);
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd_s = (rs_r == 1'b0) && (char_r[7:2] == 6'b000000);

  // The latched byte/RS/RW registers are the bus outputs themselves.
  assign lcdData = char_r;
  assign lcdRS   = rs_r;
  assign lcdRW   = rw_r;

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    char_s  = char_r;
    rs_s    = rs_r;
    rw_s    = rw_r;
    case (state_r)
      IDLE: begin
        if (dataReady) begin
          char_s  = charIn;
          rs_s    = RSin;
          rw_s    = RWin;
          cnt_s   = SETUP_LD;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_zero_s) begin
          cnt_s   = E_HI_LD;
          state_s = PULSE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_zero_s) begin
          cnt_s   = HOLD_LD;
          state_s = HOLD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_zero_s) begin
          cnt_s   = long_cmd_s ? LONG_LD : EXEC_LD;
          state_s = EXEC;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      EXEC: begin
        if (cnt_zero_s) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      char_r  <= 8'h00;
      rs_r    <= 1'b0;
      rw_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      char_r  <= char_s;
      rs_r    <= rs_s;
      rw_r    <= rw_s;
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcdE         <= 1'b0;
      sendCharDone <= 1'b0;
      busy         <= 1'b0;
      lcdDataOe    <= 1'b0;
    end else begin
      lcdE         <= (state_s == PULSE);
      sendCharDone <= (state_s == DONE);
      busy         <= (state_s != IDLE);
      lcdDataOe    <= (state_s != IDLE) && !rw_s;
    end
  end

endmodule

// File: tb/tb_lcd_send_char.sv
// Testbench for lcd_send_char: directed plus random transfers, scoreboard queue of
// expected transfers and a per-cycle monitor comparing every output.
module tb_lcd_send_char;

  localparam int S_CYC = 1;
  localparam int P_CYC = 1;
  localparam int H_CYC = 1;
  localparam int X_CYC = 80;
  localparam int L_CYC = 3200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dataReady = 1'b0;
  logic [7:0] charIn = 8'h00;
  logic       RSin = 1'b0;
  logic       RWin = 1'b0;
  logic       sendCharDone, busy, lcdE, lcdRS, lcdRW, lcdDataOe;
  logic [7:0] lcdData;

  lcd_send_char dut (
    .clk(clk), .reset(reset), .dataReady(dataReady), .charIn(charIn),
    .RSin(RSin), .RWin(RWin), .sendCharDone(sendCharDone), .busy(busy),
    .lcdE(lcdE), .lcdRS(lcdRS), .lcdRW(lcdRW), .lcdData(lcdData),
    .lcdDataOe(lcdDataOe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       rw;
    int         acc;
    int         done;
  } item_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       rw;
    bit         b2b;
    bit         junk;
    bit         rstm;
  } stim_t;

  item_t      q[$];
  stim_t      stim[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_rs = 1'b0;
  logic       last_rw = 1'b0;
  bit         abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: total cycles from the accept edge to the done pulse.
  function automatic int latency(input logic [7:0] d, input logic rs);
    int ex;
    ex = (rs == 1'b0 && d < 8'd4) ? L_CYC : X_CYC;
    return S_CYC + P_CYC + H_CYC + ex;
  endfunction

  // Monitor: every falling edge compare all outputs against the scoreboard front.
  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    bit          in_xfer;
    in_xfer = (q.size() > 0) && (cyc >= q[0].acc);
    if (in_xfer) begin
      exp_v = {1'b1,
               (cyc >= q[0].acc + S_CYC) && (cyc < q[0].acc + S_CYC + P_CYC),
               (cyc == q[0].done),
               !q[0].rw, q[0].rs, q[0].rw, q[0].data};
    end else begin
      exp_v = {4'b0000, last_rs, last_rw, last_data};
    end
    act_v = {busy, lcdE, sendCharDone, lcdDataOe, lcdRS, lcdRW, lcdData};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle%0d outputs busy/E/done/oe/rs/rw/data: got %b want %b", cyc, act_v, exp_v);
    end
    if (in_xfer) begin
      last_data = q[0].data;
      last_rs   = q[0].rs;
      last_rw   = q[0].rw;
      if (cyc == q[0].done) void'(q.pop_front());
    end
  end

  // Wait for the DUT done pulse, optionally scrambling the inputs meanwhile.
  task automatic wait_done(input bit junk, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (sendCharDone) begin
        ok = 1'b1;
        return;
      end
      if (junk) begin
        charIn    = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        RSin      = 1'($urandom);
        RWin      = 1'($urandom);
        dataReady = 1'($urandom);
      end
    end
  endtask

  task automatic add(input logic [7:0] d, input logic rs, input logic rw,
                     input bit b2b, input bit junk, input bit rstm);
    stim_t s;
    s.data = d; s.rs = rs; s.rw = rw; s.b2b = b2b; s.junk = junk; s.rstm = rstm;
    stim.push_back(s);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    long_cnt;
    item_t it;
    bit    ok;
    bit    hold;
    logic [13:0] act_v;

    add(8'h38, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8'h38, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(8'h38, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    long_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       rs;
      if ($urandom_range(0, 99) < 15 && long_cnt < 8) begin
        d  = 8'($urandom_range(0, 3));
        rs = 1'b0;
        long_cnt++;
      end else begin
        d  = 8'($urandom);
        rs = 1'($urandom);
      end
      add(d, rs, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < stim.size() && !abort; i++) begin
      hold = (i + 1 < stim.size()) && stim[i + 1].b2b;
      it.data = stim[i].data;
      it.rs   = stim[i].rs;
      it.rw   = stim[i].rw;
      if (stim[i].b2b) begin
        // At the done falling edge of the previous transfer: one IDLE cycle, then accept.
        it.acc = cyc + 2;
      end else begin
        dataReady = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        it.acc = cyc + 1;
      end
      charIn    = stim[i].data;
      RSin      = stim[i].rs;
      RWin      = stim[i].rw;
      dataReady = 1'b1;
      it.done   = it.acc + latency(it.data, it.rs);
      q.push_back(it);
      do @(negedge clk); while (cyc < it.acc);
      dataReady = hold;
      if (stim[i].rstm) begin
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        act_v = {busy, lcdE, sendCharDone, lcdDataOe, lcdRS, lcdRW, lcdData};
        vectors++;
        if (act_v !== 14'd0) begin
          miscompares++;
          $display("FAIL async_reset outputs: got %b want %b", act_v, 14'd0);
        end
        q.delete();
        last_data = 8'h00;
        last_rs   = 1'b0;
        last_rw   = 1'b0;
        dataReady = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
      end else begin
        wait_done(stim[i].junk && !hold, ok);
        if (!ok) begin
          vectors++;
          miscompares++;
          $display("FAIL done_timeout item %0d: got no sendCharDone want pulse at cycle %0d", i, it.done);
          abort = 1'b1;
        end
      end
    end

    dataReady = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_send_char.md
Name: lcd_send_char

Overview:
- Downstream consumer of the display data-control FSM. Takes one byte per request (char/command, RS, RW, dataReady) and drives the HD44780-style character LCD pins with correct setup, enable-pulse, hold and execution timing.
- Returns a one-cycle sendCharDone so the control FSM can advance to its next state.
- Write-only toward the LCD. The controller's busy flag is not polled; fixed execution delays are used instead.

Parameters:
- SETUP_CYC, 1, cycles RS/RW/data are stable before E rises (tAS); must be >=1
- E_HIGH_CYC, 1, cycles E is held high (PWEH); must be >=1
- HOLD_CYC, 1, cycles RS/RW/data are held after E falls (tH); must be >=1
- EXEC_CYC, 80, wait after HOLD for normal commands/data (40 us at 2 MHz)
- LONG_EXEC_CYC, 3200, wait after HOLD for clear/home commands (1.6 ms at 2 MHz)
- CNT_W, 16, timing counter width; must hold LONG_EXEC_CYC

Ports:
- clk  in  1  system clock (2 MHz nominal)
- reset  in  1  asynchronous, active-high reset
- dataReady  in  1  request from control FSM, level-sensitive
- charIn  in  8  byte to send
- RSin  in  1  register select (0 = command, 1 = data)
- RWin  in  1  read/write select, forwarded only
- sendCharDone  out  1  one-cycle pulse: transfer and execution wait complete
- busy  out  1  high in every state except IDLE
- lcdE  out  1  LCD enable strobe
- lcdRS  out  1  LCD register select
- lcdRW  out  1  LCD read/write
- lcdData  out  8  LCD data bus
- lcdDataOe  out  1  data bus output enable (= ~latched RW while busy, else 0)

Behaviour:
- Reset is asynchronous.
  - All outputs go to 0 immediately and the state goes to IDLE; the counter and latches clear.
  - Reset mid-transfer aborts it: E drops at once and no sendCharDone is issued.
- All outputs are registered; there are no combinational input-to-output paths.
- States and transitions: IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> DONE -> IDLE.
- IDLE: E=0, sendCharDone=0, busy=0. Bus outputs keep their last values; lcdDataOe=0.
  - If dataReady=1 at a clock edge, latch charIn/RSin/RWin, load the counter, and go to SETUP.
  - lcdData/lcdRS/lcdRW take the latched values at that same edge (the accept edge, k).
- SETUP: E=0 for SETUP_CYC cycles.
- PULSE: E=1 for E_HIGH_CYC cycles.
- HOLD: E=0 for HOLD_CYC cycles; bus unchanged.
- EXEC: E=0 for EXEC_CYC cycles, or LONG_EXEC_CYC if the latched RS=0 and latched data[7:2]=6'b0 (clear/home, bytes 0x00-0x03).
- DONE: sendCharDone=1 for exactly one cycle, then IDLE.
- Latency: sendCharDone is high in the cycle starting at edge k+N, where N = SETUP_CYC + E_HIGH_CYC + HOLD_CYC + exec. Defaults give N=83, or 3203 for long commands.
- Inputs are ignored outside IDLE. charIn/RSin/RWin changing mid-transfer has no effect on the bus.
- dataReady still high in the first IDLE cycle after DONE starts a new transfer with the inputs sampled at that edge.
  - This is required: the control FSM holds dataReady high across back-to-back command states, and changes charIn on the edge that leaves DONE.
  - There is no dead cycle beyond DONE; the minimum gap between transfers is IDLE for 1 cycle.
- dataReady low in IDLE: remain in IDLE indefinitely.
- Counter: counts down from (phase length - 1) to 0, then the phase advances. It never wraps; no overflow within the CNT_W limits.
- RWin=1 is forwarded to lcdRW with lcdDataOe=0; the sequence and timing are otherwise identical. No read data is returned.

Test Plan:
- Reset, then charIn=0x38, RSin=0, dataReady=1 for one cycle.
  -> lcdData=0x38 and lcdRS=0 at edge k; E high only during cycle k+1; sendCharDone a single pulse at k+83; busy low after.
- charIn=0x01, RS=0.
  -> long path: sendCharDone at k+3203; charIn=0x41 with RS=1 -> normal path, k+83.
- dataReady held high: 0x38, then 0x06 presented on the edge leaving DONE.
  -> two transfers; second accept edge = first DONE edge + 1; lcdData shows 0x06 on the second E pulse.
- Change charIn to 0xFF and toggle dataReady while in PULSE/EXEC.
  -> lcdData stays at the latched value; no extra transfer; one done pulse.
- Assert reset asynchronously mid-PULSE (between edges).
  -> lcdE and all outputs go to 0 immediately; no sendCharDone; the next request behaves normally.
- RWin=1, charIn=0x55.
  -> lcdRW=1 and lcdDataOe=0 throughout; done at k+83; with RWin=0, lcdDataOe=1 from k to DONE.
